// File: rtl/uart_tx_if.sv
// Host/serializer-facing signal bundle of the UART transmit frame controller.
// master = host plus serializer side, slave = the frame controller.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  Ser_Data;
  logic                  Ser_Done;
  logic                  Ser_Load;
  logic                  Ser_Enable;
  logic                  TX_OUT;
  logic                  BUSY;
  logic                  Ready;
  logic                  Frame_Err;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Ser_Data, Ser_Done,
    input  Ser_Load, Ser_Enable, TX_OUT, BUSY, Ready, Frame_Err
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Ser_Data, Ser_Done,
    output Ser_Load, Ser_Enable, TX_OUT, BUSY, Ready, Frame_Err
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: accepts a byte, sequences the serializer and
// drives start / data / optional parity / stop bits, one bit per clock.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH + 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            pen_q, pen_d;
  logic            par_q, par_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ferr_q, ferr_d;
  logic            ready;
  logic            accept;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pen_d          = pen_q;
    par_d          = par_q;
    cnt_d          = '0;
    ferr_d         = 1'b0;
    bus.Ser_Load   = 1'b0;
    bus.Ser_Enable = 1'b0;
    bus.TX_OUT     = 1'b1;
    ready          = (state_q == IDLE) || (state_q == STOP);
    accept         = bus.Data_Valid && ready;

    case (state_q)
      IDLE:   bus.TX_OUT = 1'b1;
      START: begin
        bus.TX_OUT = 1'b0;
        state_d    = DATA;
      end
      DATA: begin
        bus.TX_OUT     = bus.Ser_Data;
        bus.Ser_Enable = 1'b1;
        // cnt_q holds completed DATA cycles; this one is the (DATA_WIDTH+1)th
        if (bus.Ser_Done) begin
          state_d = pen_q ? PARITY : STOP;
        end else if (cnt_q == CW'(DATA_WIDTH)) begin
          ferr_d  = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        bus.TX_OUT = par_q;
        state_d    = STOP;
      end
      STOP: begin
        bus.TX_OUT = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept only happens in IDLE or STOP, so it may override the next state
    if (accept) begin
      bus.Ser_Load = 1'b1;
      pen_d        = bus.PAR_EN;
      par_d        = calc_parity(bus.P_DATA, bus.PAR_TYP);
      state_d      = START;
    end
  end

  assign bus.Ready     = ready;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.Frame_Err = ferr_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmit path. It accepts a parallel byte through a valid handshake and latches the byte and the parity configuration. It then sequences the downstream serializer through its load, shift and done protocol and drives the serial line with start, data, optional parity and stop bits. It sits between the host-side data interface and the serializer, and owns BUSY and the TX line.

Parameters:
DATA_WIDTH, 8, data bits per frame; must match the serializer IN_DATA_WIDTH.

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel data to send
Data_Valid  input  1  P_DATA is valid; accepted only when Ready=1
PAR_EN  input  1  1 = insert a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Ser_Data  input  1  serializer output bit (LSB first)
Ser_Done  input  1  serializer flag: last data bit is being presented
Ser_Load  output  1  load strobe to the serializer (same cycle as accept)
Ser_Enable  output  1  serializer shift/count enable
TX_OUT  output  1  serial line; idle high
BUSY  output  1  frame in progress
Ready  output  1  controller can accept Data_Valid this cycle
Frame_Err  output  1  one-cycle pulse: Ser_Done missing (timeout)

Behaviour:
- Reset is synchronous and active-high. On RST=1 at a clock edge the controller goes to IDLE. Outputs after that edge:
  - TX_OUT=1, BUSY=0, Ser_Enable=0, Ser_Load=0, Frame_Err=0.
  - Latched data, parity bit and watchdog counter cleared.
  - Reset mid-frame aborts the frame; the line returns high the next cycle.
- States: IDLE, START, DATA, PARITY, STOP. One bit period = one CLK cycle.
- TX_OUT decode from the state register:
  - IDLE = 1, START = 0, DATA = Ser_Data, PARITY = latched parity bit, STOP = 1.
- Ready = 1 in IDLE and in STOP, 0 otherwise. Ready is combinational from state.
- Accept occurs when Data_Valid & Ready. In the accept cycle:
  - Ser_Load=1 (combinational).
  - PAR_EN and PAR_TYP are latched.
  - Parity bit is latched as XOR-reduce(P_DATA) XOR PAR_TYP.
  - Next state is START.
- A Data_Valid that is not accepted is ignored; it is not queued.
- IDLE: stay while no accept; on accept go to START.
- START: one cycle, TX_OUT=0. Next state DATA.
- DATA: Ser_Enable=1. A watchdog counter increments each DATA cycle.
  - Ser_Done=1 with latched PAR_EN=1: next state PARITY.
  - Ser_Done=1 with latched PAR_EN=0: next state STOP.
  - Nominal DATA duration is DATA_WIDTH cycles.
- Watchdog: if the counter reaches DATA_WIDTH+1 without Ser_Done:
  - Frame_Err pulses for one cycle.
  - Next state STOP (parity is skipped).
  - The watchdog counter clears on leaving DATA.
- PARITY: one cycle, TX_OUT = latched parity bit. Next state STOP.
- STOP: one cycle, TX_OUT=1.
  - If accept occurs this cycle: next state START (back-to-back frame, no idle gap).
  - Otherwise: next state IDLE.
- BUSY = 1 in START, DATA, PARITY and STOP. It is registered-state decode.
- Frame length is 1 + DATA_WIDTH + PAR_EN + 1 cycles. For the default, 10 cycles without parity and 11 with parity.
- Latency: TX_OUT falls (start bit) on the cycle after accept.
- Changes to PAR_EN, PAR_TYP or P_DATA after accept do not affect the frame in progress.
- Ser_Done outside DATA is ignored.

Test Plan:
- Reset, then idle 5 cycles -> TX_OUT=1, BUSY=0, Ready=1, Ser_Enable=0, Frame_Err=0 throughout.
- P_DATA=0xA5, PAR_EN=0, Data_Valid 1 cycle -> Ser_Load pulse in the same cycle. Then TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1. BUSY high for exactly 10 cycles. Ser_Enable high for 8.
- P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1, 11-cycle frame. Repeat with PAR_TYP=1 -> parity bit 0. Repeat with P_DATA=0x03, PAR_TYP=0 -> parity bit 0.
- Data_Valid held during STOP with second byte 0x3C -> START immediately after STOP, no idle cycle. Second frame bits correct. Data_Valid asserted in DATA -> ignored, no Ser_Load.
- Serializer model withholds Ser_Done -> Frame_Err pulses once after 9 DATA cycles. Then STOP (TX_OUT=1), then IDLE, even with PAR_EN=1.
- RST asserted in the 4th DATA cycle -> next cycle IDLE, TX_OUT=1, BUSY=0, Ser_Enable=0. A new byte is then sent correctly.
